// File: rtl/instr_buffer_queue_pkg.sv
// Shared configuration and type packages for the instruction buffer queue.
//   core_config : queue sizing and derived pointer/count widths
//   core_types  : instr_buffer_info_t slot type and decode width
package core_config;
    localparam int FRONTEND_FTQ_SIZE = 8;
    localparam int IBQ_DEPTH         = 16;
    localparam int PTR_W             = $clog2(IBQ_DEPTH);
    localparam int CNT_W             = PTR_W + 1;
endpackage

package core_types;
    localparam int DECODE_WIDTH = 2;

    // One predecoded instruction slot as handed from fetch to decode.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } instr_buffer_info_t;
endpackage

// File: rtl/instr_buffer_queue_compactor.sv
// instr_compactor: combinational slot compaction for the instruction buffer.
//   valid  : per-slot valid bits from the frontend
//   wr_off : offset from tail at which each valid slot is stored
//   n_wr   : number of valid slots (entries written when not stalled)
module instr_compactor #(
    parameter int IN_WIDTH = 4,
    parameter int OFF_W    = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1,
    parameter int NW_W     = $clog2(IN_WIDTH + 1)
) (
    input  logic [IN_WIDTH-1:0]            valid,
    output logic [IN_WIDTH-1:0][OFF_W-1:0] wr_off,
    output logic [NW_W-1:0]                n_wr
);
    logic [NW_W-1:0] acc;

    // Each slot's offset is the number of valid slots below it, so sparse
    // valid patterns pack densely while keeping slot order.
    always_comb begin
        acc    = '0;
        wr_off = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            wr_off[i] = acc[OFF_W-1:0];
            acc       = acc + NW_W'(valid[i]);
        end
        n_wr = acc;
    end
endmodule

// File: rtl/instr_buffer_queue.sv
// instr_buffer_queue: decoupling FIFO between fetch/predecode and decode.
//   clk, rst_n          : core clock, async active-low reset
//   flush_i             : drop all contents and same-cycle traffic
//   frontend_instr_i    : IN_WIDTH input slots, compacted in slot order
//   frontend_stallreq_o : fewer than IN_WIDTH free entries (from registered count)
//   backend_accept_i    : prefix-accept of output slots by decode
//   backend_instr_o     : OUT_WIDTH oldest entries, slot 0 oldest
module instr_buffer_queue
    import core_types::*;
#(
    parameter int DEPTH     = core_config::IBQ_DEPTH,
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = DECODE_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush_i,
    input  instr_buffer_info_t [IN_WIDTH-1:0]   frontend_instr_i,
    output logic                                frontend_stallreq_o,
    input  logic [OUT_WIDTH-1:0]                backend_accept_i,
    output instr_buffer_info_t [OUT_WIDTH-1:0]  backend_instr_o
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int OFF_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int NW_W  = $clog2(IN_WIDTH + 1);
    localparam int NR_W  = $clog2(OUT_WIDTH + 1);

    instr_buffer_info_t mem [DEPTH];
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [CW-1:0]      count;

    logic [IN_WIDTH-1:0]            in_valid;
    logic [IN_WIDTH-1:0][OFF_W-1:0] wr_off;
    logic [NW_W-1:0]                n_wr;
    logic [NW_W-1:0]                n_wr_eff;
    logic [NR_W-1:0]                n_rd;
    logic                           wr_ok;

    always_comb begin
        for (int i = 0; i < IN_WIDTH; i++) in_valid[i] = frontend_instr_i[i].valid;
    end

    instr_compactor #(
        .IN_WIDTH (IN_WIDTH),
        .OFF_W    (OFF_W),
        .NW_W     (NW_W)
    ) u_compactor (
        .valid  (in_valid),
        .wr_off (wr_off),
        .n_wr   (n_wr)
    );

    // Conservative: entries freed by this cycle's reads are not credited.
    assign frontend_stallreq_o = (CW'(DEPTH) - count) < CW'(IN_WIDTH);
    assign wr_ok               = !frontend_stallreq_o;
    assign n_wr_eff            = wr_ok ? n_wr : '0;

    always_comb begin
        n_rd = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            backend_instr_o[i]       = mem[head + PW'(i)];
            backend_instr_o[i].valid = (CW'(i) < count) && !flush_i;
            if (backend_accept_i[i] && backend_instr_o[i].valid) n_rd = n_rd + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush_i) begin
            // Stored data is left stale; validity comes only from count.
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                for (int i = 0; i < IN_WIDTH; i++) begin
                    if (frontend_instr_i[i].valid) mem[tail + PW'(wr_off[i])] <= frontend_instr_i[i];
                end
            end
            tail  <= tail + PW'(n_wr_eff);
            head  <= head + PW'(n_rd);
            count <= count + CW'(n_wr_eff) - CW'(n_rd);
        end
    end

    generate
        for (genvar g = 1; g < OUT_WIDTH; g++) begin : g_prefix
            a_accept_prefix: assert property (@(posedge clk) disable iff (!rst_n)
                backend_accept_i[g] |-> backend_accept_i[g-1]);
        end
    endgenerate

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count <= CW'(DEPTH));

    a_no_write_on_stall: assert property (@(posedge clk) disable iff (!rst_n)
        (frontend_stallreq_o && !flush_i) |=> $stable(tail));
endmodule

// File: tb/tb_instr_buffer_queue.sv
module tb_instr_buffer_queue;
    import core_types::*;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic                          flush_i = 1'b0;
    instr_buffer_info_t [3:0]      fin = '0;
    logic                          stall;
    logic [1:0]                    accept = 2'b00;
    instr_buffer_info_t [1:0]      bo;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] seq_pc = 32'h1000_0000;
    logic [63:0] mq[$];
    logic [3:0]  two_m [6] = '{4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1100};

    instr_buffer_queue dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .flush_i             (flush_i),
        .frontend_instr_i    (fin),
        .frontend_stallreq_o (stall),
        .backend_accept_i    (accept),
        .backend_instr_o     (bo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // Fill the input slots with consecutive pcs; mask chooses live slots.
    task automatic gen_in(input logic [3:0] mask);
        for (int i = 0; i < 4; i++) begin
            fin[i].valid = mask[i];
            fin[i].pc    = seq_pc;
            fin[i].instr = $urandom;
            seq_pc       = seq_pc + 32'd4;
        end
    endtask

    function automatic logic [1:0] rand_accept();
        int r = $urandom_range(0, 2);
        return (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
    endfunction

    // Clock edge plus queue-level reference update, then inputs go idle.
    task automatic tick();
        int sz;
        int nrd;
        bit m_stall;
        @(posedge clk);
        sz      = mq.size();
        m_stall = (16 - sz) < 4;
        if (flush_i) begin
            mq.delete();
        end else begin
            nrd = 0;
            for (int i = 0; i < 2; i++) if (accept[i] && i < sz) nrd++;
            repeat (nrd) void'(mq.pop_front());
            if (!m_stall)
                for (int i = 0; i < 4; i++)
                    if (fin[i].valid) mq.push_back({fin[i].pc, fin[i].instr});
        end
        #1;
        flush_i = 1'b0;
        accept  = 2'b00;
        fin     = '0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        flush_i = 1'b0;
        accept  = 2'b00;
        fin     = '0;
        mq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (bo !== '0) begin n_fail++; $display("FAIL reset_out: got %h required 0", bo); end
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b required 0", stall); end
        gen_in(4'b1111); tick();
        gen_in(4'b0111); tick();
        n_chk++; if (dut.count !== 5'd7) begin n_fail++; $display("FAIL reset_pre_count: got %0d required 7", dut.count); end
        gen_in(4'b1111); accept = 2'b11;
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (bo[0].valid !== 1'b0 || bo[1].valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_async_valid: got %b%b required 00", bo[1].valid, bo[0].valid); end
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_async_stall: got %b required 0", stall); end
        n_chk++; if (dut.count !== 5'd0) begin n_fail++; $display("FAIL reset_async_count: got %0d required 0", dut.count); end
        mq.delete();
        fin = '0; accept = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        gen_in(4'b1111); tick();
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (bo[i].valid !== 1'b1 || bo[i].pc !== mq[i][63:32]) begin
                n_fail++; $display("FAIL reset_first_write[%0d]: got v=%b pc=%h required v=1 pc=%h", i, bo[i].valid, bo[i].pc, mq[i][63:32]); end
        end
    endtask

    task automatic test_compaction();
        do_reset();
        seq_pc = 32'h1c00_0000;
        gen_in(4'b1010); tick();
        n_chk++; if (bo[0].valid !== 1'b1 || bo[0].pc !== 32'h1c00_0004) begin
            n_fail++; $display("FAIL compact_out0: got v=%b pc=%h required v=1 pc=1c000004", bo[0].valid, bo[0].pc); end
        n_chk++; if (bo[1].valid !== 1'b1 || bo[1].pc !== 32'h1c00_000c) begin
            n_fail++; $display("FAIL compact_out1: got v=%b pc=%h required v=1 pc=1c00000c", bo[1].valid, bo[1].pc); end
        n_chk++; if (dut.count !== 5'd2) begin n_fail++; $display("FAIL compact_count: got %0d required 2", dut.count); end
    endtask

    task automatic test_fill_stall();
        logic [3:0] masks [4] = '{4'b1111, 4'b1111, 4'b1111, 4'b0001};
        do_reset();
        foreach (masks[k]) begin
            gen_in(masks[k]); tick();
            n_chk++; if (stall !== (dut.count >= 5'd13 ? 1'b1 : 1'b0) || stall !== ((16 - mq.size()) < 4)) begin
                n_fail++; $display("FAIL fill_stall_step%0d: got %b required %b", k, stall, (16 - mq.size()) < 4); end
        end
        n_chk++; if (dut.count !== 5'd13 || stall !== 1'b1) begin
            n_fail++; $display("FAIL fill_stall13: got count=%0d stall=%b required 13/1", dut.count, stall); end
        gen_in(4'b1111); tick();
        n_chk++; if (dut.count !== 5'd13) begin n_fail++; $display("FAIL fill_ignored: got %0d required 13", dut.count); end
        do_reset();
        repeat (4) begin gen_in(4'b1111); tick(); end
        n_chk++; if (dut.count !== 5'd16 || stall !== 1'b1) begin
            n_fail++; $display("FAIL fill_full: got count=%0d stall=%b required 16/1", dut.count, stall); end
        gen_in(4'b1111); tick();
        n_chk++; if (dut.count !== 5'd16) begin n_fail++; $display("FAIL fill_no_overrun: got %0d required 16", dut.count); end
        accept = 2'b11; tick();
        n_chk++; if (stall !== 1'b1 || bo[0].pc !== mq[0][63:32]) begin
            n_fail++; $display("FAIL drain1: got stall=%b pc=%h required 1 pc=%h", stall, bo[0].pc, mq[0][63:32]); end
        accept = 2'b11; tick();
        n_chk++; if (stall !== 1'b0 || dut.count !== 5'd12) begin
            n_fail++; $display("FAIL drain2: got stall=%b count=%0d required 0/12", stall, dut.count); end
    endtask

    task automatic test_wrap();
        do_reset();
        gen_in(4'b1111); tick();
        for (int c = 0; c < 40; c++) begin
            gen_in(two_m[$urandom_range(0, 5)]);
            accept = 2'b11;
            tick();
            n_chk++; if (dut.count !== 5'd4) begin n_fail++; $display("FAIL wrap_count c%0d: got %0d required 4", c, dut.count); end
            for (int i = 0; i < 2; i++) begin
                n_chk++;
                if (bo[i].valid !== 1'b1 || {bo[i].pc, bo[i].instr} !== mq[i]) begin
                    n_fail++; $display("FAIL wrap_order c%0d[%0d]: got pc=%h ins=%h required %h", c, i, bo[i].pc, bo[i].instr, mq[i]); end
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        gen_in(4'b1111); tick();
        gen_in(4'b1111); tick();
        gen_in(4'b0100); tick();
        n_chk++; if (dut.count !== 5'd9) begin n_fail++; $display("FAIL flush_pre: got %0d required 9", dut.count); end
        gen_in(4'b1111); accept = 2'b11; flush_i = 1'b1;
        #1;
        n_chk++; if (bo[0].valid !== 1'b0 || bo[1].valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_valid: got %b%b required 00", bo[1].valid, bo[0].valid); end
        tick();
        n_chk++; if (dut.count !== 5'd0 || dut.head !== 4'd0 || dut.tail !== 4'd0) begin
            n_fail++; $display("FAIL flush_ptrs: got c=%0d h=%0d t=%0d required 0/0/0", dut.count, dut.head, dut.tail); end
        n_chk++; if (bo[0].valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got %b required 0", bo[0].valid); end
        gen_in(4'b1010); tick();
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (bo[i].valid !== 1'b1 || bo[i].pc !== mq[i][63:32]) begin
                n_fail++; $display("FAIL flush_rewrite[%0d]: got pc=%h required %h", i, bo[i].pc, mq[i][63:32]); end
        end
    endtask

    task automatic test_partial_accept();
        logic [31:0] prev1;
        do_reset();
        gen_in(4'b1111); tick();
        gen_in(4'b0010); tick();
        prev1 = mq[1][63:32];
        accept = 2'b01; tick();
        n_chk++; if (bo[0].pc !== prev1) begin n_fail++; $display("FAIL partial_shift: got %h required %h", bo[0].pc, prev1); end
        n_chk++; if (dut.count !== 5'd4) begin n_fail++; $display("FAIL partial_count: got %0d required 4", dut.count); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            gen_in(4'($urandom));
            accept  = rand_accept();
            flush_i = ($urandom_range(0, 24) == 0);
            tick();
            n_chk++; if (stall !== ((16 - mq.size()) < 4)) begin
                n_fail++; $display("FAIL rand_stall c%0d: got %b required %b", c, stall, (16 - mq.size()) < 4); end
            for (int i = 0; i < 2; i++) begin
                n_chk++;
                if (bo[i].valid !== (i < mq.size())) begin
                    n_fail++; $display("FAIL rand_valid c%0d[%0d]: got %b required %b", c, i, bo[i].valid, i < mq.size());
                end else if (i < mq.size() && {bo[i].pc, bo[i].instr} !== mq[i]) begin
                    n_fail++; $display("FAIL rand_data c%0d[%0d]: got %h_%h required %h", c, i, bo[i].pc, bo[i].instr, mq[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_compaction();
        test_fill_stall();
        test_wrap();
        test_flush();
        test_partial_accept();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
